// File: rtl/uart_link_arbiter.sv
// uart_link_arbiter: shares one UART command link among NUM_REQ requesters.
// A round-robin grant picks a requester, its byte is sent, and the echo from
// the far side is checked. A timeout, mismatch or parity error causes a retry.
// After MAX_RETRIES extra attempts the requester gets a nack and the saturating
// error counter increments.
module uart_link_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 240000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         nack,
  output logic                       start_tx,
  output logic [7:0]                 data_to_tx,
  input  logic                       tx_busy,
  input  logic [7:0]                 data_received,
  input  logic                       rx_done,
  input  logic                       parity_error,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic [7:0]                 err_count
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TW   = $clog2(TIMEOUT_CYCLES);
  localparam int RW   = $clog2(MAX_RETRIES + 2);

  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]   RETRY_LAST = RW'(MAX_RETRIES);
  localparam logic [ID_W-1:0] ID_LAST    = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NUM_REQ_W  = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    TX_START,
    TX_WAIT,
    ECHO_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retryCnt_q, retryCnt_d;
  logic [ID_W-1:0]   activeId_q, activeId_d;
  logic [ID_W-1:0]   lastGrant_q, lastGrant_d;
  logic [7:0]        txData_q, txData_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] nack_q, nack_d;
  logic              startTx_q, startTx_d;
  logic              busy_q, busy_d;
  logic [7:0]        errCnt_q, errCnt_d;

  logic [ID_W:0]      rotAmt;
  logic [NUM_REQ-1:0] reqRot;
  logic [ID_W-1:0]    grantOff;
  logic [ID_W:0]      grantSum;
  logic [ID_W-1:0]    grantIdx;
  logic               grantValid;
  logic [7:0]         grantByte;
  logic               echoGood;
  logic               failAttempt;

  // Round-robin pick: rotate req so the requester after lastGrant sits at bit 0,
  // take the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    rotAmt     = {1'b0, lastGrant_q} + (ID_W+1)'(1);
    reqRot     = NUM_REQ'({req, req} >> rotAmt);
    grantValid = |reqRot;
    grantOff   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (reqRot[j]) begin
        grantOff = ID_W'(j);
      end
    end
    grantSum = rotAmt + {1'b0, grantOff};
    if (grantSum >= NUM_REQ_W) begin
      grantSum = grantSum - NUM_REQ_W;
    end
    grantIdx  = grantSum[ID_W-1:0];
    grantByte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == ID_W'(i)) begin
        grantByte = req_data[8*i +: 8];
      end
    end
  end

  // Next-state logic: transaction sequencing, echo check, retry and reporting.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retryCnt_d  = retryCnt_q;
    activeId_d  = activeId_q;
    lastGrant_d = lastGrant_q;
    txData_d    = txData_q;
    ack_d       = '0;
    nack_d      = '0;
    errCnt_d    = errCnt_q;
    failAttempt = 1'b0;
    echoGood    = rx_done && !parity_error && (data_received == txData_q);

    case (state_q)
      IDLE: begin
        // The cycle carrying an ack/nack pulse is skipped so the finished
        // requester has time to drop req before the next arbitration.
        if (grantValid && (ack_q == '0) && (nack_q == '0)) begin
          activeId_d = grantIdx;
          txData_d   = grantByte;
          retryCnt_d = '0;
          timer_d    = '0;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (tx_busy) begin
          timer_d = '0;
          state_d = TX_WAIT;
        end else if (timer_q == TIMER_LAST) begin
          failAttempt = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          timer_d = '0;
          state_d = ECHO_WAIT;
        end
      end
      ECHO_WAIT: begin
        // A valid echo wins over a timeout landing in the same cycle.
        if (echoGood) begin
          ack_d       = NUM_REQ'(1) << activeId_q;
          lastGrant_d = activeId_q;
          state_d     = IDLE;
        end else if (rx_done || (timer_q == TIMER_LAST)) begin
          failAttempt = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (failAttempt) begin
      if (retryCnt_q < RETRY_LAST) begin
        retryCnt_d = retryCnt_q + RW'(1);
        timer_d    = '0;
        state_d    = TX_START;
      end else begin
        nack_d      = NUM_REQ'(1) << activeId_q;
        lastGrant_d = activeId_q;
        if (errCnt_q != 8'hFF) begin
          errCnt_d = errCnt_q + 8'd1;
        end
        state_d = IDLE;
      end
    end

    startTx_d = (state_d == TX_START);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any byte in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retryCnt_q  <= '0;
      activeId_q  <= '0;
      lastGrant_q <= ID_LAST;
      txData_q    <= '0;
      ack_q       <= '0;
      nack_q      <= '0;
      startTx_q   <= 1'b0;
      busy_q      <= 1'b0;
      errCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retryCnt_q  <= retryCnt_d;
      activeId_q  <= activeId_d;
      lastGrant_q <= lastGrant_d;
      txData_q    <= txData_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      startTx_q   <= startTx_d;
      busy_q      <= busy_d;
      errCnt_q    <= errCnt_d;
    end
  end

  assign ack        = ack_q;
  assign nack       = nack_q;
  assign start_tx   = startTx_q;
  assign data_to_tx = txData_q;
  assign busy       = busy_q;
  assign active_id  = activeId_q;
  assign err_count  = errCnt_q;

endmodule

// File: tb/tb_uart_link_arbiter.sv
// tb_uart_link_arbiter: drives uart_link_arbiter with a scripted UART model and
// compares grants, attempt counts, ack/nack and the error counter against a
// transaction-level reference model.
module tb_uart_link_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int TIMEOUT     = 1000;
  localparam int MAX_RETRIES = 3;
  localparam int ATTEMPTS    = MAX_RETRIES + 1;
  localparam int BYTE_CYC    = 10;
  localparam int ECHO_DLY    = 4;
  localparam int ID_W        = $clog2(NUM_REQ);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   nack;
  logic                 start_tx;
  logic [7:0]           data_to_tx;
  logic                 tx_busy;
  logic [7:0]           data_received;
  logic                 rx_done;
  logic                 parity_error;
  logic                 busy;
  logic [ID_W-1:0]      active_id;
  logic [7:0]           err_count;

  uart_link_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .nack          (nack),
    .start_tx      (start_tx),
    .data_to_tx    (data_to_tx),
    .tx_busy       (tx_busy),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .busy          (busy),
    .active_id     (active_id),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef enum int {E_GOOD, E_BAD, E_PAR, E_NONE, E_EDGE} echo_e;

  echo_e plan[$];
  echo_e curCodes[ATTEMPTS];

  int checks = 0;
  int failures = 0;
  int modelLast = NUM_REQ - 1;
  int modelErr = 0;

  int                 resGrant;
  int                 resAttempts;
  int                 resStartLat;
  int                 resGapMin;
  int                 resGapMax;
  logic [NUM_REQ-1:0] resAck;
  logic [NUM_REQ-1:0] resNack;
  logic [7:0]         resByte;
  logic [7:0]         resErr;
  bit                 resTimedOut;

  // UART model: answers each start_tx with a busy window, then echoes per the plan.
  initial begin
    logic [7:0] sent;
    echo_e code;
    tx_busy = 1'b0;
    rx_done = 1'b0;
    parity_error = 1'b0;
    data_received = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (start_tx === 1'b1) begin
        sent = data_to_tx;
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (BYTE_CYC) @(posedge clk);
        #1 tx_busy = 1'b0;
        code = E_NONE;
        if (plan.size() > 0) code = plan.pop_front();
        if (code != E_NONE) begin
          if (code == E_EDGE) repeat (TIMEOUT) @(posedge clk);
          else repeat (ECHO_DLY) @(posedge clk);
          #1;
          rx_done = 1'b1;
          data_received = (code == E_BAD) ? (sent ^ 8'h96) : sent;
          parity_error = (code == E_PAR);
          @(posedge clk);
          #1;
          rx_done = 1'b0;
          parity_error = 1'b0;
        end
      end
    end
  end

  // Reference: round-robin search from the requester after the last one served.
  function automatic int modelGrant(input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (modelLast + k) % NUM_REQ;
      if (((mask >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // Reference: first good echo ends the transaction; otherwise all attempts are used.
  function automatic void expectOutcome(output int attempts, output bit good);
    attempts = ATTEMPTS;
    good = 1'b0;
    for (int i = 0; i < ATTEMPTS; i++) begin
      if (curCodes[i] == E_GOOD || curCodes[i] == E_EDGE) begin
        attempts = i + 1;
        good = 1'b1;
        break;
      end
    end
  endfunction

  function automatic void modelFinish(input int grant, input bit good);
    modelLast = grant;
    if (!good && modelErr < 255) modelErr = modelErr + 1;
  endfunction

  task automatic setPlan(input echo_e c0, input echo_e c1, input echo_e c2, input echo_e c3);
    curCodes[0] = c0;
    curCodes[1] = c1;
    curCodes[2] = c2;
    curCodes[3] = c3;
  endtask

  // Raises req, observes attempts until ack/nack (bounded), records results.
  task automatic runTxn(input logic [NUM_REQ-1:0] mask, input bit lateDrop);
    int reqCycle;
    int fallCycle;
    int budget;
    logic prevStart;
    logic prevBusy;
    plan.delete();
    for (int i = 0; i < ATTEMPTS; i++) plan.push_back(curCodes[i]);
    resGrant = -1;
    resAttempts = 0;
    resStartLat = -1;
    resGapMin = 1 << 30;
    resGapMax = -1;
    resAck = '0;
    resNack = '0;
    resByte = 8'h00;
    resErr = 8'h00;
    resTimedOut = 1'b1;
    fallCycle = -1;
    budget = ATTEMPTS * (TIMEOUT + BYTE_CYC + ECHO_DLY + 20) + 50;
    @(negedge clk);
    req = mask;
    reqCycle = cycle;
    prevStart = 1'b0;
    prevBusy = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!tx_busy && prevBusy) fallCycle = cycle;
      if (start_tx && !prevStart) begin
        resAttempts++;
        if (resGrant < 0) begin
          resGrant = int'(active_id);
          resStartLat = cycle - reqCycle;
          resByte = data_to_tx;
        end
        if (fallCycle >= 0) begin
          if (cycle - fallCycle < resGapMin) resGapMin = cycle - fallCycle;
          if (cycle - fallCycle > resGapMax) resGapMax = cycle - fallCycle;
        end
      end
      prevStart = start_tx;
      prevBusy = tx_busy;
      if ((ack | nack) != '0) begin
        resAck = ack;
        resNack = nack;
        resErr = err_count;
        resTimedOut = 1'b0;
        break;
      end
    end
    if (lateDrop) begin
      @(posedge clk);
      #1;
    end
    req = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({start_tx, busy, ack, nack} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=0", {start_tx, busy, ack, nack});
    end
    checks++;
    if (active_id !== '0 || data_to_tx !== 8'h00 || err_count !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_regs got id=%0d data=%h err=%0d want 0/00/0", active_id, data_to_tx, err_count);
    end
    reset_n = 1'b1;
    modelLast = NUM_REQ - 1;
    modelErr = 0;
  endtask

  task automatic test_round_robin;
    int expGrant;
    req_data = {8'h33, 8'h22, 8'h11};
    setPlan(E_GOOD, E_GOOD, E_GOOD, E_GOOD);
    for (int n = 0; n < 6; n++) begin
      expGrant = modelGrant(3'b111);
      runTxn(3'b111, 1'b0);
      checks++;
      if (resGrant !== expGrant || resAck !== NUM_REQ'(1 << expGrant) || resTimedOut) begin
        failures++;
        $display("[TB] FAIL rr_grant n=%0d got id=%0d ack=%b want id=%0d", n, resGrant, resAck, expGrant);
      end
      checks++;
      if (resByte !== 8'(req_data >> (8 * expGrant))) begin
        failures++;
        $display("[TB] FAIL rr_byte got=%h want=%h", resByte, 8'(req_data >> (8 * expGrant)));
      end
      modelFinish(expGrant, 1'b1);
    end
  endtask

  task automatic test_single;
    req_data = {8'h00, 8'h00, 8'hEE};
    setPlan(E_GOOD, E_GOOD, E_GOOD, E_GOOD);
    runTxn(3'b001, 1'b0);
    checks++;
    if (resAck !== 3'b001 || resNack !== 3'b000 || resTimedOut) begin
      failures++;
      $display("[TB] FAIL single_ack got ack=%b nack=%b want ack=001", resAck, resNack);
    end
    checks++;
    if (resAttempts !== 1 || resStartLat !== 1) begin
      failures++;
      $display("[TB] FAIL single_timing got attempts=%0d lat=%0d want 1/1", resAttempts, resStartLat);
    end
    @(negedge clk);
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0 || err_count !== 8'h00) begin
      failures++;
      $display("[TB] FAIL single_after got ack=%b busy=%b err=%0d want 000/0/0", ack, busy, err_count);
    end
    modelFinish(0, 1'b1);
  endtask

  task automatic test_timeout_exhaust;
    int expGrant;
    req_data = {8'h00, 8'hA7, 8'h00};
    setPlan(E_NONE, E_NONE, E_NONE, E_NONE);
    expGrant = modelGrant(3'b010);
    runTxn(3'b010, 1'b0);
    modelFinish(expGrant, 1'b0);
    checks++;
    if (resAttempts !== ATTEMPTS || resNack !== NUM_REQ'(1 << expGrant) || resAck !== '0 || resTimedOut) begin
      failures++;
      $display("[TB] FAIL timeout_nack got attempts=%0d nack=%b ack=%b want %0d attempts", resAttempts, resNack, resAck, ATTEMPTS);
    end
    // One cycle for TX_WAIT to see tx_busy fall, then the full timer span.
    checks++;
    if (resGapMin !== TIMEOUT + 1 || resGapMax !== TIMEOUT + 1) begin
      failures++;
      $display("[TB] FAIL timeout_gap got min=%0d max=%0d want=%0d", resGapMin, resGapMax, TIMEOUT + 1);
    end
    checks++;
    if (resErr !== 8'(modelErr)) begin
      failures++;
      $display("[TB] FAIL timeout_err got=%0d want=%0d", resErr, modelErr);
    end
  endtask

  task automatic test_mismatch_retry;
    int expGrant;
    req_data = {8'hC3, 8'h00, 8'h00};
    for (int v = 0; v < 2; v++) begin
      if (v == 0) setPlan(E_BAD, E_GOOD, E_GOOD, E_GOOD);
      else setPlan(E_PAR, E_GOOD, E_GOOD, E_GOOD);
      expGrant = modelGrant(3'b100);
      runTxn(3'b100, 1'b0);
      modelFinish(expGrant, 1'b1);
      checks++;
      if (resAttempts !== 2 || resAck !== 3'b100 || resNack !== 3'b000 || resTimedOut) begin
        failures++;
        $display("[TB] FAIL retry_ok v=%0d got attempts=%0d ack=%b nack=%b want 2/100/000", v, resAttempts, resAck, resNack);
      end
      checks++;
      if (resErr !== 8'(modelErr)) begin
        failures++;
        $display("[TB] FAIL retry_err got=%0d want=%0d", resErr, modelErr);
      end
    end
  endtask

  task automatic test_simultaneous;
    int expGrant;
    req_data = {8'h00, 8'h00, 8'h5C};
    setPlan(E_EDGE, E_GOOD, E_GOOD, E_GOOD);
    expGrant = modelGrant(3'b001);
    runTxn(3'b001, 1'b0);
    modelFinish(expGrant, 1'b1);
    checks++;
    if (resAttempts !== 1 || resAck !== 3'b001 || resNack !== 3'b000 || resTimedOut) begin
      failures++;
      $display("[TB] FAIL edge_echo got attempts=%0d ack=%b nack=%b want 1/001/000", resAttempts, resAck, resNack);
    end
  endtask

  task automatic test_back_to_back;
    bit sawActivity;
    req_data = {8'h00, 8'h00, 8'h7E};
    setPlan(E_GOOD, E_GOOD, E_GOOD, E_GOOD);
    runTxn(3'b001, 1'b1);
    modelFinish(0, 1'b1);
    checks++;
    if (resAck !== 3'b001 || resTimedOut) begin
      failures++;
      $display("[TB] FAIL b2b_ack got=%b want=001", resAck);
    end
    sawActivity = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (start_tx || busy) sawActivity = 1'b1;
    end
    checks++;
    if (sawActivity !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_regrant got activity=%0d want=0", sawActivity);
    end
  endtask

  task automatic test_random;
    int expGrant;
    int expAttempts;
    bit expGood;
    int r;
    logic [NUM_REQ-1:0] mask;
    for (int n = 0; n < 20; n++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      req_data = 24'($urandom);
      for (int a = 0; a < ATTEMPTS; a++) begin
        r = $urandom_range(0, 15);
        if (r == 0) curCodes[a] = E_NONE;
        else if (r <= 3) curCodes[a] = E_BAD;
        else if (r <= 5) curCodes[a] = E_PAR;
        else curCodes[a] = E_GOOD;
      end
      expGrant = modelGrant(mask);
      expectOutcome(expAttempts, expGood);
      runTxn(mask, 1'b0);
      modelFinish(expGrant, expGood);
      checks++;
      if (resGrant !== expGrant || resAttempts !== expAttempts || resTimedOut) begin
        failures++;
        $display("[TB] FAIL rand_flow n=%0d got id=%0d att=%0d want id=%0d att=%0d", n, resGrant, resAttempts, expGrant, expAttempts);
      end
      checks++;
      if (resAck !== (expGood ? NUM_REQ'(1 << expGrant) : '0) ||
          resNack !== (expGood ? '0 : NUM_REQ'(1 << expGrant))) begin
        failures++;
        $display("[TB] FAIL rand_result n=%0d got ack=%b nack=%b want good=%0d id=%0d", n, resAck, resNack, expGood, expGrant);
      end
      checks++;
      if (resErr !== 8'(modelErr)) begin
        failures++;
        $display("[TB] FAIL rand_err got=%0d want=%0d", resErr, modelErr);
      end
    end
  endtask

  task automatic test_err_saturation;
    int expGrant;
    int loops;
    logic [NUM_REQ-1:0] mask;
    setPlan(E_BAD, E_BAD, E_BAD, E_BAD);
    loops = 255 - modelErr + 2;
    for (int n = 0; n < loops; n++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      expGrant = modelGrant(mask);
      runTxn(mask, 1'b0);
      modelFinish(expGrant, 1'b0);
      if (resTimedOut) begin
        checks++;
        failures++;
        $display("[TB] FAIL sat_stall n=%0d got no ack/nack want nack", n);
        break;
      end
      if (modelErr >= 254) begin
        checks++;
        if (resErr !== 8'(modelErr) || resNack !== NUM_REQ'(1 << expGrant)) begin
          failures++;
          $display("[TB] FAIL sat_err got err=%0d nack=%b want err=%0d id=%0d", resErr, resNack, modelErr, expGrant);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit sawTxBusy;
    req_data = {8'h00, 8'hB4, 8'h19};
    setPlan(E_GOOD, E_GOOD, E_GOOD, E_GOOD);
    runTxn(3'b001, 1'b0);
    modelFinish(0, 1'b1);
    plan.delete();
    @(negedge clk);
    req = 3'b010;
    sawTxBusy = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (tx_busy) begin
        sawTxBusy = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sawTxBusy !== 1'b1 || active_id !== ID_W'(1)) begin
      failures++;
      $display("[TB] FAIL mid_pre got busy=%b txbusy=%0d id=%0d want 1/1/1", busy, sawTxBusy, active_id);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({start_tx, busy, ack, nack} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_async got=%b want=0", {start_tx, busy, ack, nack});
    end
    checks++;
    if (active_id !== '0 || data_to_tx !== 8'h00 || err_count !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_regs got id=%0d data=%h err=%0d want 0/00/0", active_id, data_to_tx, err_count);
    end
    req = '0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    modelLast = NUM_REQ - 1;
    modelErr = 0;
    setPlan(E_GOOD, E_GOOD, E_GOOD, E_GOOD);
    runTxn(3'b111, 1'b0);
    checks++;
    if (resGrant !== modelGrant(3'b111) || resAck !== NUM_REQ'(1 << modelGrant(3'b111)) || resErr !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_regrant got id=%0d ack=%b err=%0d want id=%0d", resGrant, resAck, resErr, modelGrant(3'b111));
    end
    modelFinish(modelGrant(3'b111), 1'b1);
  endtask

  // Scenario sequence, then the one-line summary.
  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout_exhaust();
    test_mismatch_retry();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_err_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
